// File: rtl/sipo_collector.sv
// ---------------------------------------------------------------------------
// sipo_collector
//
// Serial-in / parallel-out frame assembler. Words arriving one at a time on a
// valid/ready stream are packed into a LENGTH-slot frame, which is then
// presented downstream on its own valid/ready handshake. A frame can be closed
// early with flush, in which case the unwritten slots stay zero.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   reset_n    asynchronous active-low reset
//   in_valid   upstream has a word on in_data
//   in_data    serial data word
//   in_ready   collector accepts a word this cycle (FILL state, out of reset)
//   flush      close the current partial frame
//   out_valid  out_data/out_count hold a complete frame (FULL state)
//   out_ready  downstream takes the frame
//   out_data   assembled frame, index 0 = first word received
//   out_count  number of real words in the frame (1..LENGTH)
//   busy       frame partially filled or held in FULL
// ---------------------------------------------------------------------------
module sipo_collector #(
  parameter int DATA_WIDTH = 8,
  parameter int LENGTH     = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          in_valid,
  input  logic [DATA_WIDTH-1:0]         in_data,
  output logic                          in_ready,
  input  logic                          flush,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data [0:LENGTH-1],
  output logic [$clog2(LENGTH+1)-1:0]   out_count,
  output logic                          busy
);

  localparam int CW = $clog2(LENGTH + 1);
  localparam logic [CW-1:0] LAST_IDX  = CW'(LENGTH - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(LENGTH);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         outCount_q, outCount_d;
  logic [DATA_WIDTH-1:0] slots_q [0:LENGTH-1];
  logic [DATA_WIDTH-1:0] slots_d [0:LENGTH-1];
  logic                  accept;

  // in_ready is gated by reset_n so upstream sees "not ready" while the
  // collector is held in reset, and depends only on state, never on out_ready.
  assign in_ready  = reset_n && (state_q == FILL);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == FULL);
  assign out_count = outCount_q;
  assign out_data  = slots_q;
  assign busy      = (count_q != '0) || (state_q == FULL);

  // Next-state logic. The slot write uses a compare loop rather than a direct
  // index because count is one bit wider than the slot index.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    outCount_d = outCount_q;
    slots_d    = slots_q;

    case (state_q)
      FILL: begin
        if (accept) begin
          for (int i = 0; i < LENGTH; i++) begin
            if (count_q == CW'(i)) begin
              slots_d[i] = in_data;
            end
          end
          count_d = count_q + CW'(1);
          if (count_q == LAST_IDX) begin
            // last slot filled: frame is complete regardless of flush
            state_d    = FULL;
            outCount_d = FULL_CNT;
          end else if (flush) begin
            // word stored together with the flush that closes the frame
            state_d    = FULL;
            outCount_d = count_q + CW'(1);
          end
        end else if (flush && (count_q != '0)) begin
          state_d    = FULL;
          outCount_d = count_q;
        end
      end

      FULL: begin
        if (out_ready) begin
          state_d    = FILL;
          count_d    = '0;
          outCount_d = '0;
          for (int i = 0; i < LENGTH; i++) begin
            slots_d[i] = '0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= FILL;
      count_q    <= '0;
      outCount_q <= '0;
      for (int i = 0; i < LENGTH; i++) begin
        slots_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      outCount_q <= outCount_d;
      slots_q    <= slots_d;
    end
  end

endmodule

// File: tb/tb_sipo_collector.sv
// ---------------------------------------------------------------------------
// tb_sipo_collector
//
// Self-checking bench for sipo_collector (DATA_WIDTH=8, LENGTH=4). Expected
// frames are pushed to a scoreboard queue as words are driven and popped when
// the collector presents a frame.
// ---------------------------------------------------------------------------
module tb_sipo_collector;

  localparam int DW = 8;
  localparam int L  = 4;
  localparam int CW = $clog2(L + 1);

  typedef struct packed {
    logic [DW*L-1:0] data;
    logic [CW-1:0]   cnt;
  } frame_t;

  logic          clk;
  logic          reset_n;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data [0:L-1];
  logic [CW-1:0] out_count;
  logic          busy;

  int total;
  int bad;
  frame_t sb[$];
  frame_t exp;

  sipo_collector #(.DATA_WIDTH(DW), .LENGTH(L)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .busy      (busy)
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [DW*L-1:0] packOut();
    logic [DW*L-1:0] p;
    for (int i = 0; i < L; i++) p[i*DW +: DW] = out_data[i];
    return p;
  endfunction

  function automatic logic [DW*L-1:0] mkFrame(input logic [DW-1:0] b0, input logic [DW-1:0] b1,
                                               input logic [DW-1:0] b2, input logic [DW-1:0] b3);
    return {b3, b2, b1, b0};
  endfunction

  // Advance one clock; sample point is 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [DW-1:0] w);
    in_valid = 1'b1;
    in_data  = w;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (4) tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid: got %b, want 0", out_valid); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_in_ready: got %b, want 0", in_ready); end
    total++; if (packOut() !== '0) begin bad++; $display("[TB] FAIL reset_out_data: got %h, want 0", packOut()); end
    total++; if (out_count !== '0) begin bad++; $display("[TB] FAIL reset_out_count: got %0d, want 0", out_count); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b, want 0", busy); end
    reset_n = 1'b1;
    tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL release_in_ready: got %b, want 1", in_ready); end
  endtask

  task automatic test_full_frame();
    frame_t f;
    sb.push_back('{data: mkFrame(8'd1, 8'd2, 8'd3, 8'd4), cnt: CW'(4)});
    for (int w = 1; w <= 4; w++) send_word(DW'(w));
    total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL full_out_valid: got %b, want 1", out_valid); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL full_in_ready: got %b, want 0", in_ready); end
    f = sb.pop_front();
    total++; if (packOut() !== f.data) begin bad++; $display("[TB] FAIL full_data: got %h, want %h", packOut(), f.data); end
    total++; if (out_count !== f.cnt) begin bad++; $display("[TB] FAIL full_count: got %0d, want %0d", out_count, f.cnt); end
    for (int c = 0; c < 3; c++) begin
      tick();
      total++; if (out_valid !== 1'b1 || packOut() !== f.data || out_count !== f.cnt) begin
        bad++; $display("[TB] FAIL full_hold%0d: got v=%b d=%h c=%0d, want v=1 d=%h c=%0d",
                        c, out_valid, packOut(), out_count, f.data, f.cnt);
      end
    end
  endtask

  task automatic test_drain_and_next();
    drain();
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL drain_out_valid: got %b, want 0", out_valid); end
    total++; if (packOut() !== '0) begin bad++; $display("[TB] FAIL drain_slots: got %h, want 0", packOut()); end
    total++; if (out_count !== '0) begin bad++; $display("[TB] FAIL drain_count: got %0d, want 0", out_count); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL drain_in_ready: got %b, want 1", in_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL drain_busy: got %b, want 0", busy); end
    sb.push_back('{data: mkFrame(8'd5, 8'd6, 8'd7, 8'd8), cnt: CW'(4)});
    for (int w = 5; w <= 8; w++) send_word(DW'(w));
    exp = sb.pop_front();
    total++; if (out_valid !== 1'b1 || packOut() !== exp.data || out_count !== exp.cnt) begin
      bad++; $display("[TB] FAIL next_frame: got v=%b d=%h c=%0d, want v=1 d=%h c=%0d",
                      out_valid, packOut(), out_count, exp.data, exp.cnt);
    end
    drain();
  endtask

  task automatic test_gapped();
    sb.push_back('{data: mkFrame(8'd9, 8'd10, 8'd11, 8'd12), cnt: CW'(4)});
    send_word(8'd9);
    repeat (2) tick();
    total++; if (packOut() !== mkFrame(8'd9, 8'd0, 8'd0, 8'd0) || busy !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL gap_partial: got d=%h busy=%b v=%b, want d=%h busy=1 v=0",
                      packOut(), busy, out_valid, mkFrame(8'd9, 8'd0, 8'd0, 8'd0));
    end
    send_word(8'd10);
    tick();
    total++; if (packOut() !== mkFrame(8'd9, 8'd10, 8'd0, 8'd0) || out_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL gap_partial2: got d=%h v=%b, want d=%h v=0",
                      packOut(), out_valid, mkFrame(8'd9, 8'd10, 8'd0, 8'd0));
    end
    send_word(8'd11);
    send_word(8'd12);
    exp = sb.pop_front();
    total++; if (out_valid !== 1'b1 || packOut() !== exp.data || out_count !== exp.cnt) begin
      bad++; $display("[TB] FAIL gap_frame: got v=%b d=%h c=%0d, want v=1 d=%h c=%0d",
                      out_valid, packOut(), out_count, exp.data, exp.cnt);
    end
    drain();
  endtask

  task automatic test_flush();
    // flush alone after two words
    sb.push_back('{data: mkFrame(8'd5, 8'd6, 8'd0, 8'd0), cnt: CW'(2)});
    send_word(8'd5);
    send_word(8'd6);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    exp = sb.pop_front();
    total++; if (out_valid !== 1'b1 || packOut() !== exp.data || out_count !== exp.cnt) begin
      bad++; $display("[TB] FAIL flush_short: got v=%b d=%h c=%0d, want v=1 d=%h c=%0d",
                      out_valid, packOut(), out_count, exp.data, exp.cnt);
    end
    drain();
    // word and flush in the same cycle on an empty collector
    sb.push_back('{data: mkFrame(8'd7, 8'd0, 8'd0, 8'd0), cnt: CW'(1)});
    flush = 1'b1;
    send_word(8'd7);
    flush = 1'b0;
    exp = sb.pop_front();
    total++; if (out_valid !== 1'b1 || packOut() !== exp.data || out_count !== exp.cnt) begin
      bad++; $display("[TB] FAIL flush_with_word: got v=%b d=%h c=%0d, want v=1 d=%h c=%0d",
                      out_valid, packOut(), out_count, exp.data, exp.cnt);
    end
    drain();
    // flush with nothing collected
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    total++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL flush_empty: got v=%b busy=%b rdy=%b, want v=0 busy=0 rdy=1",
                      out_valid, busy, in_ready);
    end
  endtask

  task automatic test_backpressure_reset();
    sb.push_back('{data: mkFrame(8'd1, 8'd2, 8'd3, 8'd4), cnt: CW'(4)});
    for (int w = 1; w <= 4; w++) send_word(DW'(w));
    in_valid = 1'b1;
    in_data  = 8'hAA;
    repeat (2) tick();
    in_valid = 1'b0;
    exp = sb.pop_front();
    total++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || packOut() !== exp.data || out_count !== exp.cnt) begin
      bad++; $display("[TB] FAIL backpressure: got v=%b rdy=%b d=%h c=%0d, want v=1 rdy=0 d=%h c=%0d",
                      out_valid, in_ready, packOut(), out_count, exp.data, exp.cnt);
    end
    drain();
    total++; if (packOut() !== '0 || out_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL after_bp_drain: got d=%h v=%b, want d=0 v=0", packOut(), out_valid);
    end
    // two words loaded, then reset between edges
    send_word(8'h11);
    send_word(8'h22);
    total++; if (packOut() !== mkFrame(8'h11, 8'h22, 8'h00, 8'h00)) begin
      bad++; $display("[TB] FAIL pre_reset_partial: got %h, want %h", packOut(), mkFrame(8'h11, 8'h22, 8'h00, 8'h00));
    end
    #2;
    reset_n = 1'b0;
    #1;
    total++; if (packOut() !== '0 || busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL async_reset: got d=%h busy=%b rdy=%b v=%b, want d=0 busy=0 rdy=0 v=0",
                      packOut(), busy, in_ready, out_valid);
    end
    #1;
    reset_n = 1'b1;
    tick();
    sb.push_back('{data: mkFrame(8'd1, 8'd2, 8'd3, 8'd4), cnt: CW'(4)});
    for (int w = 1; w <= 4; w++) send_word(DW'(w));
    exp = sb.pop_front();
    total++; if (out_valid !== 1'b1 || packOut() !== exp.data || out_count !== exp.cnt) begin
      bad++; $display("[TB] FAIL post_reset_frame: got v=%b d=%h c=%0d, want v=1 d=%h c=%0d",
                      out_valid, packOut(), out_count, exp.data, exp.cnt);
    end
    drain();
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;

    test_reset();
    test_full_frame();
    test_drain_and_next();
    test_gapped();
    test_flush();
    test_backpressure_reset();

    total++; if (sb.size() != 0) begin bad++; $display("[TB] FAIL scoreboard_empty: got %0d left, want 0", sb.size()); end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
